// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the data-memory responder.
//   dmem_state_t    : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_WORD_BYTES : bytes per storage word
//   DMEM_MAX_WAIT   : largest supported WAIT_CYCLES value
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned DMEM_WORD_BYTES = 4;
    localparam int unsigned DMEM_MAX_WAIT   = 15;

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word storage for the data-memory responder.
// Contents are never reset.
// Ports:
//   clk     : rising-edge clock
//   wr_en   : write strobe for the selected word
//   index   : word index
//   wdata   : write data
//   be      : byte enables, bit i writes byte i
//   rd_word : current contents of the selected word
module dmem_array
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rd_word
);

    logic [31:0] memory [0:DEPTH_WORDS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < DMEM_WORD_BYTES; i++) begin
                if (be[i]) begin
                    memory[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // The responder samples this on the edge that enters RESP.
    assign rd_word = memory[index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one CPU load/store request at a time,
// inserts WAIT_CYCLES wait states, then presents a response held until
// the CPU accepts it.
// Optional build macro: DMEM_MISALIGN_ERR_EN (flag misaligned accesses as
// errors instead of ignoring req_addr[1:0]).
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake
//   req_we, req_addr     : store flag, byte address
//   req_wdata, req_be    : store data and byte enables
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata, rsp_err   : load data (0 for stores/errors), error flag
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t state, next_state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        range_err;
    logic        misalign_err;
    logic        acc_err;
    logic        enter_resp;
    logic        wr_en;
    logic [31:0] rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge,
    // before the request is latched, so take the live request in IDLE.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
    end

    assign range_err = (acc_addr[31:2] >= 30'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign_err = (acc_addr[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[1:0];
    assign misalign_err     = 1'b0;
`endif

    assign acc_err    = range_err | misalign_err;
    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign wr_en      = enter_resp && acc_we && !acc_err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_we || acc_err) ? '0 : rd_word;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .index  (acc_addr[AW+1:2]),
        .wdata  (acc_wdata),
        .be     (acc_be),
        .rd_word(rd_word)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int w, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input int unsigned hold, output logic [31:0] rdata,
                      output logic err, output int edges);
    @(negedge clk);
    check("req_ready_idle", req_ready[w], 1'b1);
    req_valid[w] = 1'b1; req_we[w] = we; req_addr[w] = addr;
    req_wdata[w] = wdata; req_be[w] = be; rsp_ready[w] = 1'b0;
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    edges = 1;
    while (!rsp_valid[w] && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    rdata = rsp_rdata[w];
    err   = rsp_err[w];
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid[w], 1'b1);
      check("hold_rdata", rsp_rdata[w], rdata);
      check("hold_err", rsp_err[w], err);
      check("hold_ready", req_ready[w], 1'b0);
    end
    req_valid[w] = 1'b1;
    rsp_ready[w] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[w] = 1'b0;
    req_valid[w] = 1'b0;
    check("release_valid", rsp_valid[w], 1'b0);
    check("release_idle", req_ready[w], 1'b1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          ed;

  initial begin
    for (int unsigned i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid[0], 1'b0);
    check("rst_rsp_err", rsp_err[0], 1'b0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", req_ready[0], 1'b1);

    xact(0, 1'b1, 32'd16, 32'h0000_0001, 4'hF, 0, rd, er, ed);
    check("sw_edges", ed, 3);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", er, 1'b0);
    check("sw_mem", dut.u_array.memory[4], 32'h0000_0001);
    xact(0, 1'b0, 32'd16, 32'h0, 4'h0, 0, rd, er, ed);
    check("lw_edges", ed, 3);
    check("lw_rdata", rd, 32'h0000_0001);
    check("lw_err", er, 1'b0);

    xact(0, 1'b1, 32'd16, 32'h1122_3344, 4'hF, 0, rd, er, ed);
    xact(0, 1'b1, 32'd16, 32'hAABB_CCDD, 4'h5, 0, rd, er, ed);
    xact(0, 1'b0, 32'd16, 32'h0, 4'h0, 0, rd, er, ed);
    check("be5_rdata", rd, 32'h11BB_33DD);

    xact(0, 1'b1, 32'd16, 32'hFFFF_FFFF, 4'h0, 0, rd, er, ed);
    check("be0_err", er, 1'b0);
    check("be0_mem", dut.u_array.memory[4], 32'h11BB_33DD);

    xact(0, 1'b0, 32'd16, 32'h0, 4'h0, 5, rd, er, ed);
    check("bp_rdata", rd, 32'h11BB_33DD);

    xact(0, 1'b1, 32'd0, 32'h5A5A_5A5A, 4'hF, 0, rd, er, ed);
    xact(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, ed);
    check("oor_ld_rdata", rd, 32'h0);
    check("oor_ld_err", er, 1'b1);
    xact(0, 1'b1, 32'h400, 32'hDEAD_0000, 4'hF, 0, rd, er, ed);
    check("oor_st_err", er, 1'b1);
    check("oor_st_mem0", dut.u_array.memory[0], 32'h5A5A_5A5A);

    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, ed);
`ifdef DMEM_MISALIGN_ERR_EN
    check("mis_err", er, 1'b1);
    check("mis_rdata", rd, 32'h0);
`else
    check("mis_err", er, 1'b0);
    check("mis_rdata", rd, 32'h11BB_33DD);
`endif

    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd16;
    req_wdata[0] = 32'hDEAD_BEEF; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("mid_wait_busy", req_ready[0], 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid[0], 1'b0);
    check("mid_rst_err", rsp_err[0], 1'b0);
    check("mid_rst_rdata", rsp_rdata[0], 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_mem", dut.u_array.memory[4], 32'h11BB_33DD);
    xact(0, 1'b0, 32'd16, 32'h0, 4'h0, 0, rd, er, ed);
    check("post_rst_edges", ed, 3);
    check("post_rst_rdata", rd, 32'h11BB_33DD);

    xact(1, 1'b1, 32'd16, 32'h0000_0001, 4'hF, 0, rd, er, ed);
    check("w0_sw_edges", ed, 1);
    check("w0_sw_err", er, 1'b0);
    xact(1, 1'b0, 32'd16, 32'h0, 4'h0, 2, rd, er, ed);
    check("w0_lw_edges", ed, 1);
    check("w0_lw_rdata", rd, 32'h0000_0001);
    check("w0_lw_err", er, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL provide parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words held.
REQ-002 The block SHALL provide parameter WAIT_CYCLES, default 2, meaning wait states (0..15) inserted between request accept and response.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: req_valid  input  1  CPU load/store request present.
REQ-007 Port: req_ready  output  1  responder accepts a request this cycle.
REQ-008 Port: req_we  input  1  1=store, 0=load.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data.
REQ-011 Port: req_be  input  4  store byte enables, bit i selects byte i.
REQ-012 Port: rsp_valid  output  1  response present.
REQ-013 Port: rsp_ready  input  1  CPU accepts the response.
REQ-014 Port: rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 Port: rsp_err  output  1  access error flag, valid with rsp_valid.

Function
REQ-016 Storage SHALL be a word-indexed array named memory[0:DEPTH_WORDS-1], indexed by req_addr[31:2], so benches can backdoor it.
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-018 IDLE: req_valid=1 at a rising edge latches we/addr/wdata/be; next state WAIT if WAIT_CYCLES>0, else RESP.
REQ-019 WAIT: a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; at 0 the next state is RESP.
REQ-020 The array access (write or read capture) SHALL occur on the edge entering RESP; rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-021 Stores SHALL update only bytes with req_be set; req_be=0 completes with no change and rsp_err=0.
REQ-022 RESP: rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1 at an edge, then go to IDLE; no new request is accepted in that same edge.
REQ-023 Word index >= DEPTH_WORDS SHALL ignore the write, return rsp_rdata=0 and rsp_err=1.
REQ-024 req_valid deasserting in WAIT or RESP SHALL not affect the in-flight transaction.

Reset
REQ-025 reset SHALL force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=1 from the cycle after release onward.
REQ-026 reset SHALL NOT clear memory contents; an in-flight store interrupted before entering RESP SHALL not be written.

Configuration
REQ-027 With DMEM_MISALIGN_ERR_EN defined, an access with req_addr[1:0]!=0 SHALL complete with rsp_err=1, rsp_rdata=0, no write.
REQ-028 Without DMEM_MISALIGN_ERR_EN, req_addr[1:0] SHALL be ignored and the access treated as word-aligned.

Structure
REQ-029 The shared cpu_pkg SHALL hold the state enum dmem_state_t (IDLE, WAIT, RESP) and constants DMEM_WORD_BYTES=4 and DMEM_MAX_WAIT=15.
REQ-030 One sub-module, dmem_array (byte-enabled synchronous storage holding memory), SHALL be instantiated; the FSM and counter stay in dmem_responder.

Verification
REQ-031 Store then load, WAIT_CYCLES=2: SW addr 16 data 0x00000001 be 0xF, then LW addr 16 -> rsp_valid 3 edges after each accept, rdata 0x00000001, err 0.
REQ-032 Partial store: memory[4]=0x11223344, store 0xAABBCCDD be 0x5 at addr 16 -> load returns 0x11BB33DD.
REQ-033 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout; first rsp_ready=1 edge -> IDLE.
REQ-034 Out of range, DEPTH_WORDS=256: load addr 0x400 -> rdata 0, err 1; memory unchanged.
REQ-035 Misaligned load addr 0x12 -> err 1 with DMEM_MISALIGN_ERR_EN; returns memory[4], err 0 without it.
REQ-036 Reset mid-WAIT of store to addr 16 -> outputs cleared, memory[4] unchanged, next request accepted normally; also repeat REQ-031 with WAIT_CYCLES=0 -> rsp_valid 1 edge after accept.
